dram_arb: RTL

DRAM_ARB -- requirements
Module: dram_arb

---
 rtl/dram_arb.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dram_arb.sv
// Three-port arbiter in front of a single DRAM command interface. Round-robin or
// fixed-priority selection, registered command outputs and a read-response timeout.
module dram_arb #(
    parameter int unsigned RR      = 1,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_req,
    input  logic [95:0] i_req_addr,
    input  logic [95:0] i_req_wdata,
    input  logic [11:0] i_req_we,
    output logic [2:0]  o_ack,
    output logic [2:0]  o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_dram_oe,
    output logic [31:0] o_dram_addr,
    output logic [31:0] o_dram_wdata,
    output logic [3:0]  o_dram_we,
    input  logic [31:0] i_dram_rdata,
    input  logic        i_dram_valid,
    input  logic        i_dram_busy
);

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StWait
    } state_e;

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [31:0] TimeoutData = 32'hDEADDEAD;

    state_e          r_state;
    state_e          w_state_d;
    logic [1:0]      r_owner;
    logic [1:0]      w_owner_d;
    logic [1:0]      r_last_grant;
    logic [1:0]      w_last_grant_d;
    logic            r_dram_oe;
    logic            w_dram_oe_d;
    logic [31:0]     r_dram_addr;
    logic [31:0]     w_dram_addr_d;
    logic [31:0]     r_dram_wdata;
    logic [31:0]     w_dram_wdata_d;
    logic [3:0]      r_dram_we;
    logic [3:0]      w_dram_we_d;
    logic [2:0]      r_rvalid;
    logic [2:0]      w_rvalid_d;
    logic [31:0]     r_rdata;
    logic [31:0]     w_rdata_d;
    logic            r_err;
    logic            w_err_d;
    logic [CntW-1:0] r_wait_cnt;
    logic [CntW-1:0] w_wait_cnt_d;

    logic [31:0] w_port_addr  [3];
    logic [31:0] w_port_wdata [3];
    logic [3:0]  w_port_we    [3];
    logic [1:0]  w_order      [3];
    logic        w_grant_vld;
    logic [1:0]  w_grant_idx;
    logic        w_accept;
    logic        w_timeout;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [2:0] port_onehot(input logic [1:0] p);
        return 3'b001 << p;
    endfunction

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            w_port_addr[p]  = i_req_addr[32*p +: 32];
            w_port_wdata[p] = i_req_wdata[32*p +: 32];
            w_port_we[p]    = i_req_we[4*p +: 4];
        end
    end

    // Priority list: w_order[0] is the most favoured port this cycle.
    always_comb begin
        if (RR != 0) begin
            w_order[0] = next_port(r_last_grant);
        end else begin
            w_order[0] = 2'd0;
        end
        w_order[1]  = next_port(w_order[0]);
        w_order[2]  = next_port(w_order[1]);
        w_grant_vld = |i_req;
        w_grant_idx = w_order[2];
        for (int k = 1; k >= 0; k--) begin
            if (i_req[w_order[k]]) begin
                w_grant_idx = w_order[k];
            end
        end
    end

    assign w_accept  = (r_state == StCmd) && !i_dram_busy && !i_rst;
    assign w_timeout = (TIMEOUT != 0) && (r_wait_cnt == CntLast);

    always_comb begin
        w_state_d      = r_state;
        w_owner_d      = r_owner;
        w_last_grant_d = r_last_grant;
        w_dram_oe_d    = r_dram_oe;
        w_dram_addr_d  = r_dram_addr;
        w_dram_wdata_d = r_dram_wdata;
        w_dram_we_d    = r_dram_we;
        w_rvalid_d     = 3'b000;
        w_rdata_d      = r_rdata;
        w_err_d        = r_err;
        w_wait_cnt_d   = r_wait_cnt;

        unique case (r_state)
            StIdle: begin
                if (w_grant_vld) begin
                    w_state_d      = StCmd;
                    w_owner_d      = w_grant_idx;
                    w_dram_oe_d    = 1'b1;
                    w_dram_addr_d  = w_port_addr[w_grant_idx];
                    w_dram_wdata_d = w_port_wdata[w_grant_idx];
                    w_dram_we_d    = w_port_we[w_grant_idx];
                end
            end
            StCmd: begin
                if (!i_dram_busy) begin
                    w_last_grant_d = r_owner;
                    w_dram_oe_d    = 1'b0;
                    w_dram_we_d    = 4'h0;
                    w_wait_cnt_d   = '0;
                    w_state_d      = (r_dram_we != 4'h0) ? StIdle : StWait;
                end
            end
            StWait: begin
                // Real data wins over a timeout landing in the same cycle.
                if (i_dram_valid) begin
                    w_rvalid_d = port_onehot(r_owner);
                    w_rdata_d  = i_dram_rdata;
                    w_state_d  = StIdle;
                end else if (w_timeout) begin
                    w_rvalid_d = port_onehot(r_owner);
                    w_rdata_d  = TimeoutData;
                    w_err_d    = 1'b1;
                    w_state_d  = StIdle;
                end else if (TIMEOUT != 0) begin
                    w_wait_cnt_d = r_wait_cnt + 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_owner      <= 2'd0;
            r_last_grant <= 2'd2;
            r_dram_oe    <= 1'b0;
            r_dram_addr  <= 32'h0;
            r_dram_wdata <= 32'h0;
            r_dram_we    <= 4'h0;
            r_rvalid     <= 3'b000;
            r_rdata      <= 32'h0;
            r_err        <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            r_state      <= w_state_d;
            r_owner      <= w_owner_d;
            r_last_grant <= w_last_grant_d;
            r_dram_oe    <= w_dram_oe_d;
            r_dram_addr  <= w_dram_addr_d;
            r_dram_wdata <= w_dram_wdata_d;
            r_dram_we    <= w_dram_we_d;
            r_rvalid     <= w_rvalid_d;
            r_rdata      <= w_rdata_d;
            r_err        <= w_err_d;
            r_wait_cnt   <= w_wait_cnt_d;
        end
    end

    assign o_ack        = w_accept ? port_onehot(r_owner) : 3'b000;
    assign o_rvalid     = r_rvalid;
    assign o_rdata      = r_rdata;
    assign o_err        = r_err;
    assign o_dram_oe    = r_dram_oe;
    assign o_dram_addr  = r_dram_addr;
    assign o_dram_wdata = r_dram_wdata;
    assign o_dram_we    = r_dram_we;

endmodule
